// File: rtl/bcd3_to_bin.sv
// Sequential 3-digit BCD to 10-bit binary converter (reverse double dabble, one shift per clock).
// Optional invalid-digit check enabled by defining BCD3_TO_BIN_CHECK_EN.
module bcd3_to_bin (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] cen,
    input  logic [3:0] dec,
    input  logic [3:0] uni,
    output logic [9:0] bin,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [11:0] sr, sr_sh, sr_adj;
    logic [9:0]  acc, acc_sh;
    logic [3:0]  cnt;
    logic        last;

    function automatic logic [3:0] fix(input logic [3:0] f);
        return (f >= 4'd8) ? f - 4'd3 : f;
    endfunction

    // One iteration: shift the digit/accumulator pair right, then correct each digit field.
    assign {sr_sh, acc_sh} = {1'b0, sr, acc[9:1]};
    assign sr_adj = {fix(sr_sh[11:8]), fix(sr_sh[7:4]), fix(sr_sh[3:0])};
    assign last   = (state == SHIFT) && (cnt == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == 4'd9) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

`ifdef BCD3_TO_BIN_CHECK_EN
    logic bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad <= 1'b0;
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            bad <= (cen > 4'd9) || (dec > 4'd9) || (uni > 4'd9);
            err <= 1'b0;
        end else if (last && bad) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            acc  <= '0;
            cnt  <= '0;
            bin  <= '0;
            done <= 1'b0;
        end else begin
            done <= last;
            case (state)
                IDLE: if (start) begin
                    sr  <= {cen, dec, uni};
                    acc <= '0;
                    cnt <= '0;
                end
                SHIFT: begin
                    sr  <= sr_adj;
                    acc <= acc_sh;
                    cnt <= cnt + 4'd1;
`ifdef BCD3_TO_BIN_CHECK_EN
                    if (last) bin <= bad ? 10'd0 : acc_sh;
`else
                    if (last) bin <= acc_sh;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd3_to_bin.sv
// Directed bench for bcd3_to_bin: table-driven conversions plus hand-written handshake/reset sequences.
module tb_bcd3_to_bin;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] cen = '0, dec = '0, uni = '0;
    logic [9:0] bin;
    logic       busy, done, err;

    int nvec = 0;
    int nerr = 0;

    bcd3_to_bin dut (
        .clk(clk), .rst(rst), .start(start),
        .cen(cen), .dec(dec), .uni(uni),
        .bin(bin), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] c, d, u;
        int         exp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one conversion from IDLE; checks latency, result, bin hold and busy length.
    task automatic run_conv(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                            input int exp, input bit check_bin);
        int prev, lat, bcnt, hold_bad;
        prev = bin; lat = 0; bcnt = 0; hold_bad = 0;
        @(negedge clk);
        cen = c; dec = d; uni = u; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy) bcnt++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin lat = k; break; end
            if (bin != prev) hold_bad = 1;
        end
        chk("latency", lat, 10);
        chk("bin_hold", hold_bad, 0);
        if (check_bin) chk("bin", bin, exp);
        for (int k = 0; k < 5 && busy; k++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
        end
        chk("busy_cycles", bcnt, 11);
        chk("done_width", done, 0);
    endtask

    initial begin
        int dcnt, t1, t2;
        tbl[0] = '{4'd9, 4'd9, 4'd9, 999};
        tbl[1] = '{4'd0, 4'd0, 4'd0, 0};
        tbl[2] = '{4'd2, 4'd5, 4'd5, 255};
        tbl[3] = '{4'd1, 4'd2, 4'd3, 123};
        tbl[4] = '{4'd5, 4'd0, 4'd1, 501};
        tbl[5] = '{4'd0, 4'd0, 4'd9, 9};
        tbl[6] = '{4'd0, 4'd1, 4'd0, 10};

        #12;
        chk("reset_bin", bin, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_conv(tbl[i].c, tbl[i].d, tbl[i].u, tbl[i].exp, 1'b1);

        // Extra start requests during a conversion must be ignored.
        dcnt = 0;
        @(negedge clk);
        cen = 4'd4; dec = 4'd5; uni = 4'd6; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 9);
            if (k == 3) begin cen = 4'd7; dec = 4'd7; uni = 4'd7; end
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                chk("ignored_start_bin", bin, 456);
            end
        end
        start = 1'b0;
        chk("ignored_start_done_count", dcnt, 1);

        // Reset five cycles into a conversion.
        @(negedge clk);
        cen = 4'd8; dec = 4'd0; uni = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_bin", bin, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        run_conv(4'd8, 4'd0, 4'd0, 800, 1'b1);

        // start held high: one conversion every 12 cycles.
        t1 = -1; t2 = -1;
        @(negedge clk);
        cen = 4'd3; dec = 4'd2; uni = 4'd1; start = 1'b1;
        for (int k = 0; k < 40 && t2 < 0; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (t1 < 0) t1 = k; else t2 = k;
            end
        end
        chk("held_start_bin", bin, 321);
        chk("held_start_period", t2 - t1, 12);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(posedge clk);

`ifdef BCD3_TO_BIN_CHECK_EN
        run_conv(4'd1, 4'hA, 4'd0, 0, 1'b1);
        chk("check_err_set", err, 1);
        @(negedge clk);
        cen = 4'd0; dec = 4'd4; uni = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("check_err_cleared", err, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("check_bin_after", bin, 42);
        chk("check_err_after", err, 0);
`else
        chk("err_tied_low", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
